face_frame_tx: RTL and testbench

- Display-side transmitter for the pet state machine.
- Periodically snapshots the face code, selected-state index and five 3-bit stat values, then serialises them as a 5-byte frame over a mode-0 SPI-style link to the external display controller.
- After each complete frame it emits a one-cycle `done` pulse. The state machine's face sequencer advances on that pulse, which closes the face/done loop.

---
 rtl/face_frame_tx.sv | 96 +++++++++
 tb/tb_face_frame_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/face_frame_tx.sv
// face_frame_tx: snapshots face/state/stat inputs and sends them as a 5-byte mode-0 SPI frame, pulsing done at frame end
// Ports: clk, rst (async, active low); face, state_test and five 3-bit stat values in;
//        sclk/mosi/cs_n serial link, done (one-cycle end-of-frame pulse), busy (= ~cs_n) out.
// Build option: define FACE_FRAME_CRC_EN to make the last byte a CRC-8 (poly 0x07) instead of an XOR checksum.
module face_frame_tx #(
  parameter int CLK_DIV   = 25,
  parameter int FRAME_GAP = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] face,
  input  logic [2:0] state_test,
  input  logic [2:0] food_value,
  input  logic [2:0] sleep_value,
  input  logic [2:0] fun_value,
  input  logic [2:0] happy_value,
  input  logic [2:0] health_value,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic       done,
  output logic       busy
);
  typedef enum logic [2:0] {GAP, LOAD, LOW, HIGH, FINISH} state_t;
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [19:0] GAP_LAST = 20'(FRAME_GAP - 1);
  state_t      r_state, w_next;
  logic [19:0] r_gap;
  logic [7:0]  r_div;
  logic [5:0]  r_idx;
  logic [39:0] r_sr;
  logic        r_sclk, r_mosi, r_cs_n, r_done, r_busy;
  logic [31:0] w_head;
  logic [7:0]  w_chk;
  logic        w_step, w_shift, w_sclk, w_mosi, w_cs_n, w_done;
  assign w_head = {8'hA5, 1'b0, face, state_test, food_value, sleep_value, fun_value[2:1],
                   fun_value[0], happy_value, health_value, 1'b0};
`ifdef FACE_FRAME_CRC_EN
  always_comb begin
    w_chk = '0;
    for (int i = 31; i >= 0; i--) w_chk = {w_chk[6:0], 1'b0} ^ ((w_chk[7] ^ w_head[i]) ? 8'h07 : 8'h00);
  end
`else
  assign w_chk = w_head[31:24] ^ w_head[23:16] ^ w_head[15:8] ^ w_head[7:0];
`endif
  assign w_step = r_div == DIV_LAST;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= GAP;
      r_gap   <= '0;
      r_div   <= '0;
      r_idx   <= '0;
      r_sr    <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gap   <= (r_state == GAP && w_next == GAP) ? r_gap + 1'b1 : '0;
      r_div   <= (w_next == r_state && (r_state == LOW || r_state == HIGH)) ? r_div + 1'b1 : '0;
      r_sr    <= (w_next == LOAD) ? {w_head, w_chk} : w_shift ? {r_sr[38:0], 1'b0} : r_sr;
      r_idx   <= (w_next == LOAD) ? 6'd39 : w_shift ? r_idx - 1'b1 : r_idx;
      r_sclk  <= w_sclk;
      r_mosi  <= w_mosi;
      r_cs_n  <= w_cs_n;
      r_done  <= w_done;
      r_busy  <= ~w_cs_n;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      GAP:     w_next = (r_gap == GAP_LAST) ? LOAD : GAP;
      LOAD:    w_next = LOW;
      LOW:     w_next = w_step ? HIGH : LOW;
      HIGH:    w_next = w_step ? ((r_idx == 6'd0) ? FINISH : LOW) : HIGH;
      default: w_next = GAP;
    endcase
  end
  // Outputs are computed from the upcoming state and registered, so each state's
  // output values appear on the pins exactly while that state is held.
  always_comb begin
    w_shift = r_state == HIGH && w_next == LOW;
    w_sclk  = w_next == HIGH;
    w_cs_n  = !(w_next inside {LOAD, LOW, HIGH});
    w_done  = w_next == FINISH;
    w_mosi  = (w_next == LOAD) ? w_head[31] : w_shift ? r_sr[38] : w_cs_n ? 1'b0 : r_mosi;
  end
  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign cs_n = r_cs_n;
  assign done = r_done;
  assign busy = r_busy;
endmodule

// File: tb/tb_face_frame_tx.sv
// tb_face_frame_tx: directed, table-driven bench for face_frame_tx with CLK_DIV=2, FRAME_GAP=10
module tb_face_frame_tx;
  typedef struct {
    logic [3:0]  face;
    logic [2:0]  st, food, sleep, fun, happy, health;
    logic [39:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] face;
  logic [2:0] state_test, food_value, sleep_value, fun_value, happy_value, health_value;
  logic sclk, mosi, cs_n, done, busy;
  int cyc = 0, pass = 0, total = 0;
  int busy_err = 0, mosi_err = 0, done_cnt = 0, ne = 0;
  logic p_sclk = 1'b0, p_mosi = 1'b0, p_cs = 1'b1;
  logic [39:0] sh = '0;
  logic [39:0] frames[$];
  int edges[$], falls[$], rises[$];
  logic dn[$];
  vec_t tv[4];
  int rel, nf, nd;
  face_frame_tx #(.CLK_DIV(2), .FRAME_GAP(10)) dut (
    .clk(clk), .rst(rst), .face(face), .state_test(state_test),
    .food_value(food_value), .sleep_value(sleep_value), .fun_value(fun_value),
    .happy_value(happy_value), .health_value(health_value),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (busy !== ~cs_n) busy_err <= busy_err + 1;
    if (p_sclk && sclk && mosi !== p_mosi) mosi_err <= mosi_err + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (p_cs && !cs_n) begin
      falls.push_back(cyc);
      sh <= '0;
      ne <= 0;
    end
    if (!cs_n && sclk && !p_sclk) begin
      sh <= {sh[38:0], mosi};
      ne <= ne + 1;
    end
    if (rst && !p_cs && cs_n) begin
      rises.push_back(cyc);
      frames.push_back(sh);
      edges.push_back(ne);
      dn.push_back(done);
    end
    p_sclk <= sclk;
    p_mosi <= mosi;
    p_cs   <= cs_n;
  end
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", nm, a, e);
    else pass++;
  endtask
  function automatic logic [39:0] fix(input logic [39:0] f);
`ifdef FACE_FRAME_CRC_EN
    logic [7:0] c = '0;
    for (int i = 39; i >= 8; i--) c = (c[7] ^ f[i]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return {f[39:8], c};
`else
    return f;
`endif
  endfunction
  task automatic apply(input vec_t v);
    face = v.face; state_test = v.st; food_value = v.food; sleep_value = v.sleep;
    fun_value = v.fun; happy_value = v.happy; health_value = v.health;
  endtask
  task automatic wait_frames(input int n);
    for (int k = 0; k < 3000 && frames.size() < n; k++) @(negedge clk);
    chk($sformatf("frame%0d_arrived", n), 64'(frames.size() >= n), 64'd1);
  endtask
  task automatic wait_fall(input int n);
    for (int k = 0; k < 3000 && falls.size() < n; k++) @(negedge clk);
    chk($sformatf("fall%0d_seen", n), 64'(falls.size() >= n), 64'd1);
  endtask
  initial begin
    tv[0] = '{4'h8, 3'd1, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 40'hA541B6DA88};
    tv[1] = '{4'hB, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 40'hA5580000FD};
    tv[2] = '{4'hF, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 40'hA57FFFFEDB};
    tv[3] = '{4'h3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 40'hA51D29CC5D};
`ifdef FACE_FRAME_CRC_EN
    chk("death_crc_byte", 64'(fix(tv[1].exp) & 40'hFF), 64'hC4);
`endif
    apply(tv[0]);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {sclk, mosi, cs_n, done, busy}, 5'b00100);
    rst = 1'b1;
    rel = cyc;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) apply(tv[i]);
      wait_frames(i + 1);
      if (frames.size() > i) begin
        chk($sformatf("frame%0d_data", i), frames[i], fix(tv[i].exp));
        chk($sformatf("frame%0d_edges", i), edges[i], 40);
        chk($sformatf("frame%0d_done_at_rise", i), dn[i], 1'b1);
      end
    end
    if (falls.size() >= 2 && rises.size() >= 1) begin
      chk("first_fall_after_rel", falls[0] - rel, 10);
      chk("cs_low_cycles", rises[0] - falls[0], 161);
      chk("cs_high_cycles", falls[1] - rises[0], 11);
      chk("frame_period", falls[1] - falls[0], 172);
    end
    apply(tv[0]);
    wait_fall(5);
    @(posedge clk);
    #1 face = 4'h2;
    wait_frames(5);
    if (frames.size() >= 5) chk("snapshot_current", frames[4], fix(tv[0].exp));
    wait_frames(6);
    if (frames.size() >= 6) chk("snapshot_next", frames[5], fix(40'hA511B6DAD8));
    wait_fall(7);
    for (int k = 0; k < 1000 && ne < 20; k++) @(negedge clk);
    chk("midframe_reached_bit20", 64'(ne >= 20), 64'd1);
    nf = frames.size();
    nd = done_cnt;
    rst = 1'b0;
    #1;
    chk("async_rst_cs_n", cs_n, 1'b1);
    chk("async_rst_sclk", sclk, 1'b0);
    chk("async_rst_busy_mosi", {busy, mosi, done}, 3'b000);
    repeat (3) @(negedge clk);
    chk("no_done_after_abort", done_cnt, nd);
    rst = 1'b1;
    rel = cyc;
    wait_fall(8);
    if (falls.size() >= 8) chk("refall_after_rel", falls[7] - rel, 10);
    wait_frames(nf + 1);
    if (frames.size() > nf) begin
      chk("fresh_frame_data", frames[nf], fix(40'hA511B6DAD8));
      chk("fresh_frame_edges", edges[nf], 40);
    end
    chk("done_pulses_match_frames", done_cnt, nd + 1);
    chk("frames_after_reset", frames.size(), nf + 1);
    repeat (2) @(negedge clk);
    chk("busy_eq_not_cs_n", busy_err, 0);
    chk("mosi_stable_sclk_high", mosi_err, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
